// File: rtl/fb_fill_master_pkg.sv
// Shared definitions for the frame-buffer fill master: VGA bus register map,
// idle bus address and FSM state encodings.
package fb_fill_master_pkg;

    localparam logic [7:0] BusAddrColHi  = 8'hB0;
    localparam logic [7:0] BusAddrColLo  = 8'hB1;
    localparam logic [7:0] BusAddrFbHi   = 8'hB2;
    localparam logic [7:0] BusAddrFbLo   = 8'hB3;
    localparam logic [7:0] BusAddrFbData = 8'hB4;
    localparam logic [7:0] BusIdleAddr   = 8'hFF;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq   = 3'd1;
    localparam logic [2:0] StHaddr = 3'd2;
    localparam logic [2:0] StLaddr = 3'd3;
    localparam logic [2:0] StData  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    // States that own a bus write slot when granted.
    function automatic logic is_bus_state(input logic [2:0] st);
        return (st == StHaddr) || (st == StLaddr) || (st == StData);
    endfunction

    // States in which the bus is requested and the engine reports busy.
    function automatic logic is_active_state(input logic [2:0] st);
        return (st == StReq) || is_bus_state(st);
    endfunction

endpackage

// File: rtl/fb_fill_master.sv
// Frame-buffer span fill initiator on the 8-bit VGA register bus.
// Define FILL_HADDR_SKIP_EN to skip the high-address write while addr[14:8] is unchanged.
module fb_fill_master
    import fb_fill_master_pkg::*;
#(
    parameter int unsigned ADDR_STEP = 1,
    parameter int unsigned FB_ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [FB_ADDR_W-1:0] start_addr,
    input  logic [FB_ADDR_W-1:0] length,
    input  logic [7:0]           pattern,
    output logic                 busy,
    output logic                 done,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [7:0]           bus_addr,
    inout  wire  [7:0]           bus_data,
    output logic                 bus_we
);

    logic [2:0]           state_q, state_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [FB_ADDR_W-1:0] count_q, count_d;
    logic [7:0]           pattern_q, pattern_d;
    logic [FB_ADDR_W-1:0] addr_next;
    logic [7:0]           data_out;
    logic                 drive;

    // Address arithmetic wraps naturally at the counter width.
    assign addr_next = addr_q + FB_ADDR_W'(ADDR_STEP);
    assign drive     = is_bus_state(state_q) && bus_gnt;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        pattern_d = pattern_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = start_addr;
                    count_d   = length;
                    pattern_d = pattern;
                    state_d   = (length == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (bus_gnt) state_d = StHaddr;
            end
            StHaddr: begin
                state_d = bus_gnt ? StLaddr : StHaddr;
            end
            StLaddr: begin
                state_d = bus_gnt ? StData : StHaddr;
            end
            StData: begin
                if (!bus_gnt) begin
                    // Reissue the whole triplet: the CPU may have touched B2/B3 meanwhile.
                    state_d = StHaddr;
                end else begin
                    count_d = count_q - FB_ADDR_W'(1);
                    addr_d  = addr_next;
                    if (count_q == FB_ADDR_W'(1)) begin
                        state_d = StDone;
                    end else begin
`ifdef FILL_HADDR_SKIP_EN
                        state_d = ((addr_next >> 8) == (addr_q >> 8)) ? StLaddr : StHaddr;
`else
                        state_d = StHaddr;
`endif
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort lets the current (granted) cycle complete, then drops the remaining count.
        if (abort && is_active_state(state_q)) state_d = StDone;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            count_q   <= '0;
            pattern_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            pattern_q <= pattern_d;
        end
    end

    always_comb begin
        bus_addr = BusIdleAddr;
        data_out = '0;
        if (drive) begin
            case (state_q)
                StHaddr: begin
                    bus_addr = BusAddrFbHi;
                    data_out = 8'(addr_q >> 8);
                end
                StLaddr: begin
                    bus_addr = BusAddrFbLo;
                    data_out = addr_q[7:0];
                end
                StData: begin
                    bus_addr = BusAddrFbData;
                    data_out = pattern_q;
                end
                default: begin
                    bus_addr = BusIdleAddr;
                    data_out = '0;
                end
            endcase
        end
    end

    assign bus_we   = drive;
    assign bus_data = drive ? data_out : 8'hzz;
    assign bus_req  = is_active_state(state_q);
    assign busy     = is_active_state(state_q);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_fb_fill_master.sv
// Randomised self-checking bench for fb_fill_master against a span-level write model.
// Expectations follow FILL_HADDR_SKIP_EN when it is defined for the build.
module tb_fb_fill_master;

    localparam int STEP = 1;
`ifdef FILL_HADDR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        bus_gnt = 1'b0;
    logic [14:0] start_addr = '0;
    logic [14:0] length = '0;
    logic [7:0]  pattern = '0;
    wire         busy, done, bus_req, bus_we;
    wire  [7:0]  bus_addr;
    wire  [7:0]  bus_data;

    fb_fill_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .length     (length),
        .pattern    (pattern),
        .busy       (busy),
        .done       (done),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_we     (bus_we)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bus observer state
    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, last_we_cyc = -1;
    int req_cnt = 0, idle_bad = 0, order_bad = 0, start_cyc = 0;
    bit need_b2 = 1'b1;
    bit gnt_rand = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus_we === 1'b1) begin
            wr_q.push_back({bus_addr, bus_data});
            last_we_cyc = cyc;
            if (need_b2 && bus_addr !== 8'hB2) order_bad++;
            need_b2 = 1'b0;
        end else if (bus_addr !== 8'hFF) begin
            idle_bad++;
        end
        if (bus_req && !bus_gnt) need_b2 = 1'b1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) idle_bad++;
        end
        if (bus_req) req_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (gnt_rand) bus_gnt = ($urandom_range(0, 3) != 0);
    end

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0; req_cnt = 0; idle_bad = 0; order_bad = 0;
        done_cyc = -1; last_we_cyc = -1; need_b2 = 1'b1;
    endtask

    // Span model: the writes an uninterrupted fill must produce.
    task automatic build_exp(input logic [14:0] sa, input int len, input logic [7:0] pat);
        logic [14:0] a;
        logic [6:0]  prev_hi;
        exp_q.delete();
        a = sa;
        prev_hi = '0;
        for (int i = 0; i < len; i++) begin
            if (!SKIP || i == 0 || a[14:8] != prev_hi) exp_q.push_back({8'hB2, 1'b0, a[14:8]});
            exp_q.push_back({8'hB3, a[7:0]});
            exp_q.push_back({8'hB4, pat});
            prev_hi = a[14:8];
            a = a + 15'(STEP);
        end
    endtask

    // Effective FB address of every data write as seen by the VGA register file.
    task automatic eff_scan(input logic [14:0] sa, input logic [7:0] pat,
                            output int nb4, output int bad);
        logic [7:0]  hi, lo;
        logic [14:0] a;
        hi = 8'hxx; lo = 8'hxx; a = sa; nb4 = 0; bad = 0;
        foreach (wr_q[i]) begin
            case (wr_q[i][15:8])
                8'hB2: hi = wr_q[i][7:0];
                8'hB3: lo = wr_q[i][7:0];
                8'hB4: begin
                    if ({hi, lo} !== {1'b0, a} || wr_q[i][7:0] !== pat) bad++;
                    nb4++;
                    a = a + 15'(STEP);
                end
                default: bad++;
            endcase
        end
    endtask

    task automatic do_start(input logic [14:0] sa, input logic [14:0] len, input logic [7:0] pat,
                            input logic ab);
        @(posedge clk);
        #1;
        start_addr = sa; length = len; pattern = pat; start = 1'b1; abort = ab;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s done_timeout got=none required=pulse within %0d cycles", name, bound);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_exact(input string name);
        int first;
        first = -1;
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count got=%0d required=%0d", name, wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (first < 0 && wr_q[i] !== exp_q[i]) first = i;
        checks++;
        if (first >= 0) begin
            errors++;
            $display("FAIL %s write_seq[%0d] got=%h required=%h", name, first, wr_q[first],
                     exp_q[first]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_we_cyc + 1) begin
            errors++;
            $display("FAIL %s done_timing got=cnt%0d@%0d required=cnt1@%0d", name, done_cnt,
                     done_cyc, last_we_cyc + 1);
        end
        checks++;
        if (idle_bad != 0 || order_bad != 0) begin
            errors++;
            $display("FAIL %s bus_idle_order got=%0d/%0d required=0/0", name, idle_bad, order_bad);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, bus_req, bus_we, bus_addr} !== {4'b0000, 8'hFF}) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b/%h required=0000/ff", busy, done, bus_req,
                     bus_we, bus_addr);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_fill(input string name, input logic [14:0] sa, input int len,
                                   input logic [7:0] pat, input logic ab);
        gnt_rand = 1'b0;
        bus_gnt = 1'b1;
        clear_mon();
        build_exp(sa, len, pat);
        do_start(sa, 15'(len), pat, ab);
        wait_done(name, 200);
        check_exact(name);
    endtask

    task automatic test_grant_drop();
        int n0, nb4, bad, n;
        gnt_rand = 1'b0;
        bus_gnt = 1'b1;
        clear_mon();
        do_start(15'h0020, 15'd3, 8'h3C, 1'b0);
        n = 0;
        while (wr_q.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (!SKIP) begin
            @(posedge clk);
            #1;
        end
        n0 = wr_q.size();
        bus_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus_we !== 1'b0 || bus_addr !== 8'hFF || bus_req !== 1'b1) begin
                errors++;
                $display("FAIL grant_drop_idle got=we%b/%h/req%b required=we0/ff/req1", bus_we,
                         bus_addr, bus_req);
            end
            @(posedge clk);
            #1;
        end
        bus_gnt = 1'b1;
        wait_done("grant_drop", 200);
        checks++;
        if (wr_q.size() < n0 + 2 || wr_q[n0] !== 16'hB200 || wr_q[n0+1] !== 16'hB321) begin
            errors++;
            $display("FAIL grant_drop_reissue got=%0d writes required=B200,B321 at %0d",
                     wr_q.size(), n0);
        end
        eff_scan(15'h0020, 8'h3C, nb4, bad);
        checks++;
        if (nb4 != 3 || bad != 0) begin
            errors++;
            $display("FAIL grant_drop_data got=%0d writes/%0d bad required=3/0", nb4, bad);
        end
    endtask

    task automatic test_zero_length();
        gnt_rand = 1'b0;
        bus_gnt = 1'b1;
        clear_mon();
        do_start(15'h1234, 15'd0, 8'h77, 1'b0);
        wait_done("zero_len", 10);
        checks++;
        if (req_cnt != 0 || wr_q.size() != 0 || done_cnt != 1 || done_cyc - start_cyc > 3) begin
            errors++;
            $display("FAIL zero_len got=req%0d/wr%0d/done%0d@+%0d required=0/0/1@<=3", req_cnt,
                     wr_q.size(), done_cnt, done_cyc - start_cyc);
        end
    endtask

    task automatic test_abort();
        int nb4, bad, n;
        gnt_rand = 1'b0;
        bus_gnt = 1'b1;
        clear_mon();
        do_start(15'h0100, 15'd10, 8'h99, 1'b0);
        n = 0;
        nb4 = 0;
        while (nb4 < 2 && n < 100) begin
            @(negedge clk);
            nb4 = 0;
            foreach (wr_q[i]) if (wr_q[i][15:8] == 8'hB4) nb4++;
            n++;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done("abort", 50);
        eff_scan(15'h0100, 8'h99, nb4, bad);
        checks++;
        if (nb4 < 2 || nb4 > 3 || bad != 0) begin
            errors++;
            $display("FAIL abort_writes got=%0d/%0d bad required=2..3/0", nb4, bad);
        end
        checks++;
        if (done_cnt != 1 || bus_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_end got=done%0d/req%b/busy%b required=1/0/0", done_cnt, bus_req,
                     busy);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        gnt_rand = 1'b0;
        bus_gnt = 1'b1;
        clear_mon();
        build_exp(15'h0040, 4, 8'h5A);
        do_start(15'h0040, 15'd4, 8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start_addr = 15'h4444; length = 15'd9; pattern = 8'hEE; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_exact("start_ignored");
        req_cnt = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (req_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done got=req%0d/busy%b required=0/0", req_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        gnt_rand = 1'b0;
        bus_gnt = 1'b1;
        clear_mon();
        do_start(15'h0200, 15'd5, 8'h81, 1'b0);
        n = 0;
        while (wr_q.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus_req, bus_we, bus_addr} !== {4'b0000, 8'hFF}) begin
            errors++;
            $display("FAIL reset_async got=%b%b%b%b/%h required=0000/ff", busy, done, bus_req,
                     bus_we, bus_addr);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        test_basic_fill("after_reset", 15'h0010, 3, 8'hAA, 1'b0);
    endtask

    task automatic test_random();
        logic [14:0] sa;
        logic [7:0]  pat;
        int len, nb4, bad;
        for (int it = 0; it < 8; it++) begin
            sa = (it == 0) ? 15'h7FFA : 15'($urandom);
            pat = 8'($urandom);
            len = $urandom_range(1, 12);
            clear_mon();
            bus_gnt = 1'b1;
            gnt_rand = 1'b1;
            do_start(sa, 15'(len), pat, 1'b0);
            wait_done("random", 2000);
            gnt_rand = 1'b0;
            eff_scan(sa, pat, nb4, bad);
            checks++;
            if (nb4 != len || bad != 0) begin
                errors++;
                $display("FAIL random_data it%0d sa=%h got=%0d/%0d bad required=%0d/0", it, sa,
                         nb4, bad, len);
            end
            checks++;
            if (done_cnt != 1 || idle_bad != 0 || order_bad != 0) begin
                errors++;
                $display("FAIL random_proto it%0d got=done%0d/idle%0d/order%0d required=1/0/0",
                         it, done_cnt, idle_bad, order_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill("t1_fill", 15'h0010, 3, 8'hAA, 1'b0);
        test_basic_fill("t3_wrap", 15'h7FFF, 2, 8'h55, 1'b0);
        test_basic_fill("start_beats_abort", 15'h00FE, 4, 8'hC3, 1'b1);
        test_grant_drop();
        test_zero_length();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
